// File: rtl/monolith_sponge_absorb_if.sv
// Message-in / digest-out handshake bundle for the sponge absorb block.
interface monolith_sponge_absorb_if #(
    parameter int unsigned WORD_WIDTH  = 31,
    parameter int unsigned DIGEST_SIZE = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_digest [DIGEST_SIZE];

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_digest
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_digest
    );
endinterface

// File: rtl/monolith_sponge_absorb.sv
// Sponge absorb controller over GF(2^W-1): buffers RATE words, adds them into the state, runs an external permutation.
// Optional padding (1 after the final word, extra block when full) enabled by MONOLITH_ABSORB_PAD_EN.
module monolith_sponge_absorb #(
    parameter int unsigned WORD_WIDTH  = 31,
    parameter int unsigned STATE_SIZE  = 16,
    parameter int unsigned RATE        = 8,
    parameter int unsigned DIGEST_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    monolith_sponge_absorb_if.slave io,
    output logic                  busy,
    output logic                  perm_reset,
    output logic [WORD_WIDTH-1:0] perm_state_in  [STATE_SIZE],
    input  logic [WORD_WIDTH-1:0] perm_state_out [STATE_SIZE],
    input  logic                  perm_valid
);

    localparam int unsigned CNT_W = $clog2(RATE + 1);
    localparam logic [WORD_WIDTH:0] MODULUS = {1'b0, {WORD_WIDTH{1'b1}}};

    typedef enum logic [1:0] {FILL, START, WAIT, DONE} fsm_e;

    fsm_e                  fsm_q, fsm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_blk_q, last_blk_d;
    logic [WORD_WIDTH-1:0] blk_q    [RATE];
    logic [WORD_WIDTH-1:0] blk_d    [RATE];
    logic [WORD_WIDTH-1:0] sponge_q [STATE_SIZE];
    logic [WORD_WIDTH-1:0] sponge_d [STATE_SIZE];
    logic [WORD_WIDTH-1:0] pin_q    [STATE_SIZE];
    logic [WORD_WIDTH-1:0] pin_d    [STATE_SIZE];
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  perm_reset_q, perm_reset_d;
`ifdef MONOLITH_ABSORB_PAD_EN
    logic                  pad_pend_q, pad_pend_d;
`endif

    function automatic logic [WORD_WIDTH-1:0] mod_add(input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
        logic [WORD_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MODULUS) s = s - MODULUS;
        return s[WORD_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= FILL;
            cnt_q        <= '0;
            last_blk_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            perm_reset_q <= 1'b1;
            for (int i = 0; i < RATE; i++) blk_q[i] <= '0;
            for (int i = 0; i < STATE_SIZE; i++) begin
                sponge_q[i] <= '0;
                pin_q[i]    <= '0;
            end
`ifdef MONOLITH_ABSORB_PAD_EN
            pad_pend_q   <= 1'b0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            cnt_q        <= cnt_d;
            last_blk_q   <= last_blk_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            perm_reset_q <= perm_reset_d;
            blk_q        <= blk_d;
            sponge_q     <= sponge_d;
            pin_q        <= pin_d;
`ifdef MONOLITH_ABSORB_PAD_EN
            pad_pend_q   <= pad_pend_d;
`endif
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        last_blk_d = last_blk_q;
        blk_d      = blk_q;
        sponge_d   = sponge_q;
        pin_d      = pin_q;
`ifdef MONOLITH_ABSORB_PAD_EN
        pad_pend_d = pad_pend_q;
`endif

        unique case (fsm_q)
            FILL: begin
                if (io.in_valid) begin
                    for (int i = 0; i < RATE; i++)
                        if (cnt_q == CNT_W'(i)) blk_d[i] = io.in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(RATE) || io.in_last) begin
                        fsm_d      = START;
                        last_blk_d = io.in_last;
`ifdef MONOLITH_ABSORB_PAD_EN
                        // Pad marker goes right after the last word; a full block defers it to an extra block
                        if (io.in_last) begin
                            for (int i = 0; i < RATE; i++)
                                if (cnt_d == CNT_W'(i)) blk_d[i] = WORD_WIDTH'(1);
                            if (cnt_d == CNT_W'(RATE)) begin
                                last_blk_d = 1'b0;
                                pad_pend_d = 1'b1;
                            end
                        end
`endif
                    end
                end
            end
            START: begin
                for (int i = 0; i < RATE; i++) pin_d[i] = mod_add(sponge_q[i], blk_q[i]);
                for (int i = RATE; i < STATE_SIZE; i++) pin_d[i] = sponge_q[i];
                for (int i = 0; i < RATE; i++) blk_d[i] = '0;
                cnt_d = '0;
                fsm_d = WAIT;
            end
            WAIT: begin
                if (perm_valid) begin
                    sponge_d = perm_state_out;
                    fsm_d    = last_blk_q ? DONE : FILL;
`ifdef MONOLITH_ABSORB_PAD_EN
                    if (pad_pend_q) begin
                        blk_d[0]   = WORD_WIDTH'(1);
                        pad_pend_d = 1'b0;
                        last_blk_d = 1'b1;
                        fsm_d      = START;
                    end
`endif
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    for (int i = 0; i < STATE_SIZE; i++) sponge_d[i] = '0;
                    for (int i = 0; i < RATE; i++) blk_d[i] = '0;
                    cnt_d      = '0;
                    last_blk_d = 1'b0;
                    fsm_d      = FILL;
                end
            end
            default: fsm_d = FILL;
        endcase

        // Status outputs are registered from the next state so they line up with fsm_q
        in_ready_d   = (fsm_d == FILL);
        out_valid_d  = (fsm_d == DONE);
        busy_d       = !((fsm_d == FILL) && (cnt_d == '0));
        perm_reset_d = (fsm_d != WAIT);
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign busy         = busy_q;
    assign perm_reset   = perm_reset_q;
    assign perm_state_in = pin_q;

    always_comb begin
        for (int i = 0; i < DIGEST_SIZE; i++) io.out_digest[i] = sponge_q[i];
    end

endmodule
